// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: pipeline-side front end for mem_system (load/store handshake, drain, timeout, hit/miss stats)
//
// Ports:
//    clk, rst_n                      clock, asynchronous active-low reset
//    req_valid/req_wr/req_addr/req_wdata   pipeline request (store when req_wr=1)
//    req_ready                       request accepted this cycle (IDLE & req_valid)
//    pipe_stall                      freeze pipeline until the response pulse
//    resp_valid/resp_rdata/resp_err/resp_hit   one-cycle completion
//    mem_Addr/mem_DataIn/mem_Rd/mem_Wr     registered drive to mem_system
//    mem_DataOut/mem_Done/mem_err          returns from mem_system
//    hit_cnt/miss_cnt                saturating access statistics
module mem_req_ctrl #(
   parameter int TIMEOUT   = 64,
   parameter int HIT_LAT   = 3,
   parameter int DRAIN_CYC = 2,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   input  logic             req_wr,
   input  logic [15:0]      req_addr,
   input  logic [15:0]      req_wdata,
   output logic             req_ready,
   output logic             pipe_stall,
   output logic             resp_valid,
   output logic [15:0]      resp_rdata,
   output logic             resp_err,
   output logic             resp_hit,
   output logic [15:0]      mem_Addr,
   output logic [15:0]      mem_DataIn,
   output logic             mem_Rd,
   output logic             mem_Wr,
   input  logic [15:0]      mem_DataOut,
   input  logic             mem_Done,
   input  logic             mem_err,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);
   localparam int TW = $clog2(TIMEOUT + DRAIN_CYC) + 1;
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] DR_LAST = TW'(DRAIN_CYC - 1);
   localparam logic [TW-1:0] HL      = TW'(HIT_LAT);
   typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;
   state_t state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic rd_q, rd_d, wr_q, wr_d, sticky_q, sticky_d, mis_q, mis_d;
   logic valid_q, valid_d, err_q, err_d, hit_q, hit_d;
   logic [CNT_W-1:0] hcnt_q, hcnt_d, mcnt_q, mcnt_d;
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rd_d     = rd_q;
      wr_d     = wr_q;
      sticky_d = sticky_q;
      mis_d    = mis_q;
      valid_d  = 1'b0;
      err_d    = 1'b0;
      hit_d    = 1'b0;
      rdata_d  = 16'h0;
      hcnt_d   = hcnt_q;
      mcnt_d   = mcnt_q;
      case (state_q)
         IDLE: if (req_valid) begin
            if (req_addr[0]) begin
               // misaligned: answer straight away without touching memory
               mis_d   = 1'b1;
               valid_d = 1'b1;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               mis_d    = 1'b0;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               rd_d     = ~req_wr;
               wr_d     = req_wr;
               timer_d  = '0;
               sticky_d = 1'b0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            timer_d  = timer_q + 1'b1;
            sticky_d = sticky_q | mem_err;
            // Done takes priority over a timeout in the same cycle
            if (mem_Done) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               valid_d = 1'b1;
               err_d   = sticky_q | mem_err;
               hit_d   = timer_q < HL;
               rdata_d = rd_q ? mem_DataOut : 16'h0;
               state_d = RESP;
            end else if (timer_q == TO_LAST) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               valid_d = 1'b1;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (!mis_q) begin
               hcnt_d = (hit_q && !(&hcnt_q)) ? hcnt_q + 1'b1 : hcnt_q;
               mcnt_d = (!hit_q && !(&mcnt_q)) ? mcnt_q + 1'b1 : mcnt_q;
            end
            timer_d = '0;
            state_d = DRAIN;
         end
         default: begin
            // DRAIN: Rd/Wr already low; stray Done pulses are ignored
            timer_d = timer_q + 1'b1;
            state_d = (timer_q == DR_LAST) ? IDLE : DRAIN;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         timer_q  <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         sticky_q <= 1'b0;
         mis_q    <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
         hit_q    <= 1'b0;
         hcnt_q   <= '0;
         mcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         sticky_q <= sticky_d;
         mis_q    <= mis_d;
         valid_q  <= valid_d;
         err_q    <= err_d;
         hit_q    <= hit_d;
         hcnt_q   <= hcnt_d;
         mcnt_q   <= mcnt_d;
      end
   end
   assign req_ready  = (state_q == IDLE) & req_valid;
   assign pipe_stall = req_valid & ~valid_q;
   assign resp_valid = valid_q;
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;
   assign resp_hit   = hit_q;
   assign mem_Addr   = addr_q;
   assign mem_DataIn = wdata_q;
   assign mem_Rd     = rd_q;
   assign mem_Wr     = wr_q;
   assign hit_cnt    = hcnt_q;
   assign miss_cnt   = mcnt_q;
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: randomized transaction-level check of mem_req_ctrl against a memory model and reference
module tb_mem_req_ctrl;
   localparam int TO = 64, HLAT = 3, DC = 2, CW = 16;
   logic clk = 0, rst_n = 0;
   logic req_valid = 0, req_wr = 0;
   logic [15:0] req_addr = 0, req_wdata = 0;
   logic req_ready, pipe_stall, resp_valid, resp_err, resp_hit, mem_Rd, mem_Wr;
   logic [15:0] resp_rdata, mem_Addr, mem_DataIn;
   logic [15:0] mem_DataOut = 0;
   logic mem_Done = 0, mem_err = 0;
   logic [CW-1:0] hit_cnt, miss_cnt;
   mem_req_ctrl #(.TIMEOUT(TO), .HIT_LAT(HLAT), .DRAIN_CYC(DC), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .pipe_stall(pipe_stall), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .resp_hit(resp_hit), .mem_Addr(mem_Addr),
      .mem_DataIn(mem_DataIn), .mem_Rd(mem_Rd), .mem_Wr(mem_Wr), .mem_DataOut(mem_DataOut),
      .mem_Done(mem_Done), .mem_err(mem_err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;
   int checks = 0, failures = 0;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   // memory system model and transaction-level reference state
   logic [15:0] mem [logic [15:0]];
   logic [15:0] refmem [logic [15:0]];
   logic [15:0] cur_addr = 0;
   bit cur_wr = 0, err_cfg = 0, dbl_cfg = 0;
   int lat_cfg = 3, mc = 0, dbl_at = -1, nresp = 0, last_resp = 0, hc = 0, ms = 0;
   always @(negedge clk) begin
      mem_Done = 0;
      mem_err = 0;
      mem_DataOut = 16'($urandom);
      if (!rst_n) mc = 0;
      else if (mem_Rd | mem_Wr) begin
         mc++;
         chk("hold_addr", mem_Addr, cur_addr);
         chk("hold_rdwr", {mem_Rd, mem_Wr}, {~cur_wr, cur_wr});
         if (cur_wr) chk("hold_data", mem_DataIn, req_wdata);
         if (err_cfg && mc == 1) mem_err = 1;
         if (mc == lat_cfg) begin
            mem_Done = 1;
            mem_DataOut = mem.exists(mem_Addr) ? mem[mem_Addr] : 16'h0;
            if (mem_Wr) mem[mem_Addr] = mem_DataIn;
            if (dbl_cfg) dbl_at = cyc + 2;
         end
      end else begin
         mc = 0;
         if (cyc == dbl_at) mem_Done = 1;
      end
   end
   always @(negedge clk) if (rst_n) begin
      chk("stall", pipe_stall, req_valid & ~resp_valid);
      if (resp_valid) begin
         nresp++;
         chk("no_overlap", req_ready, 0);
      end
   end
   function automatic logic [15:0] rd_ref(input logic [15:0] a);
      return refmem.exists(a) ? refmem[a] : 16'h0;
   endfunction
   task automatic do_req(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                         input int lat, input bit err, input bit dbl, input bit held, input int gap);
      int a, r, n, dt;
      bit seen, mis, eerr, ehit;
      logic [15:0] erd;
      if (!held) begin
         req_valid = 0;
         repeat (gap) @(negedge clk);
         #1;
      end
      cur_addr = addr; cur_wr = wr; lat_cfg = lat; err_cfg = err; dbl_cfg = dbl;
      req_wr = wr; req_addr = addr; req_wdata = data; req_valid = 1;
      #1;
      n = 0;
      while (!req_ready && n < 200) begin
         @(negedge clk); #1; n++;
      end
      chk("accept_bound", n < 200, 1);
      a = cyc;
      if (held) chk("accept_cyc", a, last_resp + DC + 1);
      mis = addr[0];
      if (mis) begin
         dt = 1; eerr = 1; ehit = 0; erd = 0;
      end else if (lat == 0 || lat > TO) begin
         dt = TO + 1; eerr = 1; ehit = 0; erd = 0;
      end else begin
         dt = lat + 1; eerr = err; ehit = (lat <= HLAT); erd = wr ? 16'h0 : rd_ref(addr);
         if (wr) refmem[addr] = data;
      end
      seen = 0; n = 0;
      do begin
         @(negedge clk); #1;
         seen |= mem_Rd | mem_Wr;
         n++;
      end while (!resp_valid && n < TO + 20);
      chk("resp_bound", resp_valid, 1);
      r = cyc;
      chk("resp_lat", r - a, dt);
      chk("rdata", resp_rdata, erd);
      chk("err", resp_err, eerr);
      chk("hit", resp_hit, ehit);
      if (mis) chk("no_mem", seen, 0);
      else if (ehit) hc++;
      else ms++;
      last_resp = r;
      @(negedge clk); #1;
      chk("resp_pulse", resp_valid, 0);
      chk("hit_cnt", hit_cnt, hc);
      chk("miss_cnt", miss_cnt, ms);
   endtask
   initial begin
      #500000;
      $display("FAIL watchdog");
      $fatal(1);
   end
   initial begin
      int n0, w, lt, d;
      logic [15:0] ad;
      mem[16'h0040] = 16'hBEEF; refmem[16'h0040] = 16'hBEEF;
      for (int i = 0; i < 8; i++) begin
         d = $urandom;
         mem[16'(i * 2 + 16'h0100)] = 16'(d); refmem[16'(i * 2 + 16'h0100)] = 16'(d);
      end
      repeat (3) @(negedge clk);
      chk("rst_valid", resp_valid, 0);
      chk("rst_rdwr", {mem_Rd, mem_Wr}, 0);
      chk("rst_addr", mem_Addr, 0);
      chk("rst_cnt", {hit_cnt, miss_cnt}, 0);
      rst_n = 1;
      @(negedge clk);
      do_req(0, 16'h0040, 0, 3, 0, 0, 0, 1);
      do_req(1, 16'h1840, 16'h1234, 8, 0, 1, 0, 1);
      do_req(0, 16'h1840, 0, 2, 0, 0, 0, 3);
      do_req(0, 16'h0041, 0, 3, 0, 0, 0, 1);
      do_req(0, 16'h0100, 0, 0, 0, 0, 0, 1);
      do_req(0, 16'h0102, 0, 4, 0, 0, 1, 0);
      n0 = nresp;
      do_req(0, 16'h0104, 0, 3, 0, 0, 0, 1);
      do_req(0, 16'h0106, 0, 1, 0, 0, 1, 0);
      do_req(0, 16'h0108, 0, 5, 0, 0, 1, 0);
      chk("b2b_pulses", nresp - n0, 3);
      do_req(0, 16'h0040, 0, 2, 1, 0, 1, 0);
      do_req(1, 16'h010A, 16'h5A5A, TO, 0, 0, 0, 2);
      for (int i = 0; i < 40; i++) begin
         w = $urandom_range(0, 1);
         ad = 16'h0100 + 16'($urandom_range(0, 15) * 2);
         if ($urandom_range(0, 7) == 0) ad[0] = 1;
         lt = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 10);
         do_req(w[0], ad, 16'($urandom), lt, $urandom_range(0, 9) == 0,
                w[0] && $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3));
      end
      req_valid = 0;
      repeat (4) @(negedge clk);
      cur_addr = 16'h0040; cur_wr = 0; lat_cfg = 30; err_cfg = 0; dbl_cfg = 0;
      req_wr = 0; req_addr = 16'h0040; req_valid = 1;
      #1;
      n0 = 0;
      while (!req_ready && n0 < 20) begin
         @(negedge clk); #1; n0++;
      end
      chk("rst_accept", req_ready, 1);
      @(negedge clk); req_valid = 0;
      repeat (4) @(negedge clk);
      chk("rst_busy", mem_Rd, 1);
      #2 rst_n = 0;
      #1;
      chk("arst_rdwr", {mem_Rd, mem_Wr}, 0);
      chk("arst_addr", mem_Addr, 0);
      chk("arst_resp", {resp_valid, resp_err, resp_hit}, 0);
      chk("arst_rdata", resp_rdata, 0);
      chk("arst_cnt", {hit_cnt, miss_cnt}, 0);
      hc = 0; ms = 0;
      @(negedge clk); rst_n = 1;
      @(negedge clk);
      do_req(0, 16'h0040, 0, 3, 0, 0, 0, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
